// File: rtl/fifo_pkg.sv
// Shared definitions for the nibble FIFO: default sizes, data type and
// pointer-width helper used by the top level and the storage array.
package fifo_pkg;

    localparam int FIFO_WIDTH_DEF = 4;
    localparam int FIFO_DEPTH_DEF = 8;

    typedef logic [3:0] nibble_t;

    // Pointer width: index bits plus one wrap bit.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Storage array for the FIFO: one write port without reset and a registered
// read port with a read-enable. The read register resets to zero and holds
// its value when no read is requested.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH_DEF,
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n_i,
    input  logic                     wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
    output logic [WIDTH-1:0]         rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // Write port: contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Read port: capture the addressed word on a read, otherwise hold.
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sync_fifo_4.sv
// Synchronous FIFO buffering nibbles from the upstream register. Holds the
// pointers, occupancy count, accept logic and sticky protocol-error flags;
// the storage lives in fifo_mem.
module sync_fifo_4
    import fifo_pkg::*;
#(
    parameter int WIDTH       = FIFO_WIDTH_DEF,
    parameter int DEPTH       = FIFO_DEPTH_DEF,
    parameter int AFULL_LEVEL = 6
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    output logic                   full,
    output logic                   almost_full,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   rd_valid,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    input  logic                   clr_err,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] count_q, count_d;
    logic          rd_valid_q;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          wr_accept_s;
    logic          rd_accept_s;

    // Status flags decode the registered count only, so they never glitch.
    assign full        = (count_q == PW'(DEPTH));
    assign empty       = (count_q == {PW{1'b0}});
    assign almost_full = (count_q >= PW'(AFULL_LEVEL));

    // A read frees a slot in the same edge, so a write at full still fits.
    assign rd_accept_s = rd_en && !empty;
    assign wr_accept_s = wr_en && (!full || rd_accept_s);

    // Next-state pointers and occupancy from the accepted operations.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_accept_s) begin
            wr_ptr_d = wr_ptr_q + {{(PW-1){1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd_accept_s) begin
            rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({wr_accept_s, rd_accept_s})
            2'b10:   count_d = count_q + {{(PW-1){1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{(PW-1){1'b0}}, 1'b1};
            default: count_d = count_q;
        endcase
    end

    // Sticky error flags: a new error takes priority over a clear.
    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (wr_en && !wr_accept_s) begin
            overflow_d = 1'b1;
        end else if (clr_err) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
        if (rd_en && empty) begin
            underflow_d = 1'b1;
        end else if (clr_err) begin
            underflow_d = 1'b0;
        end else begin
            underflow_d = underflow_q;
        end
    end

    // State registers; reset discards contents without needing a clock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rd_valid_q  <= rd_accept_s;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk       (clk),
        .rst_n_i   (reset_n),
        .wr_en_i   (wr_accept_s),
        .wr_addr_i (wr_ptr_q[AW-1:0]),
        .wr_data_i (wr_data),
        .rd_en_i   (rd_accept_s),
        .rd_addr_i (rd_ptr_q[AW-1:0]),
        .rd_data_o (rd_data)
    );

    assign count     = count_q;
    assign rd_valid  = rd_valid_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_sync_fifo_4.sv
// Self-checking bench for sync_fifo_4: a table of per-cycle vectors with
// expected outputs, plus hand-written wrap-around and mid-operation reset
// sequences checked against a queue of expected words.
module tb_sync_fifo_4;

    logic       clk;
    logic       reset_n;
    logic       wr_en;
    logic [3:0] wr_data;
    logic       full;
    logic       almost_full;
    logic       rd_en;
    logic [3:0] rd_data;
    logic       rd_valid;
    logic       empty;
    logic [3:0] count;
    logic       clr_err;
    logic       overflow;
    logic       underflow;

    int n_vec;
    int n_err;

    typedef struct {
        logic       wr;
        logic [3:0] wd;
        logic       rd;
        logic       clr;
        int         cnt;
        logic       fu;
        logic       em;
        logic       af;
        logic       ov;
        logic       un;
        logic       rv;
        logic [3:0] rdd;
    } vec_t;

    vec_t       tbl[$];
    logic [3:0] sb[$];

    sync_fifo_4 dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .full        (full),
        .almost_full (almost_full),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .empty       (empty),
        .count       (count),
        .clr_err     (clr_err),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic wr, input logic [3:0] wd, input logic rd,
                       input logic clr, input int cnt, input logic ov,
                       input logic un, input logic rv, input logic [3:0] rdd);
        vec_t v;
        v.wr = wr; v.wd = wd; v.rd = rd; v.clr = clr; v.cnt = cnt;
        v.fu = (cnt == 8); v.em = (cnt == 0); v.af = (cnt >= 6);
        v.ov = ov; v.un = un; v.rv = rv; v.rdd = rdd;
        tbl.push_back(v);
    endtask

    task automatic idle_inputs();
        wr_en = 1'b0; wr_data = 4'h0; rd_en = 1'b0; clr_err = 1'b0;
    endtask

    initial begin
        int mc;
        logic wa;
        logic ra;
        logic [3:0] expw;
        n_vec = 0;
        n_err = 0;
        reset_n = 1'b0;
        idle_inputs();

        // ---------------- reset then idle ----------------
        @(posedge clk); @(posedge clk); #1;
        check("rst_empty", int'(empty), 1);
        check("rst_count", int'(count), 0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("idle_empty", int'(empty), 1);
        check("idle_full", int'(full), 0);
        check("idle_count", int'(count), 0);
        check("idle_rv", int'(rd_valid), 0);
        check("idle_ov", int'(overflow), 0);
        check("idle_un", int'(underflow), 0);

        // ---------------- table: fill, overflow, simultaneous ----------------
        for (int i = 1; i <= 8; i++) add(1'b1, 4'(i), 1'b0, 1'b0, i, 1'b0, 1'b0, 1'b0, 4'h0);
        add(1'b1, 4'hF, 1'b0, 1'b0, 8, 1'b1, 1'b0, 1'b0, 4'h0);  // overflow
        add(1'b0, 4'h0, 1'b0, 1'b1, 8, 1'b0, 1'b0, 1'b0, 4'h0);  // clear
        add(1'b1, 4'h9, 1'b1, 1'b0, 8, 1'b0, 1'b0, 1'b1, 4'h1);  // wr+rd at full
        for (int i = 2; i <= 9; i++) add(1'b0, 4'h0, 1'b1, 1'b0, 9 - i, 1'b0, 1'b0, 1'b1, 4'(i));
        add(1'b1, 4'h5, 1'b1, 1'b0, 1, 1'b0, 1'b1, 1'b0, 4'h9);  // wr+rd at empty
        add(1'b0, 4'h0, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b1, 4'h5);  // read + clear
        add(1'b0, 4'h0, 1'b1, 1'b1, 0, 1'b0, 1'b1, 1'b0, 4'h5);  // set beats clear
        add(1'b0, 4'h0, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 4'h5);  // clear

        foreach (tbl[k]) begin
            wr_en = tbl[k].wr; wr_data = tbl[k].wd; rd_en = tbl[k].rd; clr_err = tbl[k].clr;
            @(posedge clk); #1;
            check($sformatf("v%0d_count", k), int'(count), tbl[k].cnt);
            check($sformatf("v%0d_full", k), int'(full), int'(tbl[k].fu));
            check($sformatf("v%0d_empty", k), int'(empty), int'(tbl[k].em));
            check($sformatf("v%0d_afull", k), int'(almost_full), int'(tbl[k].af));
            check($sformatf("v%0d_ovf", k), int'(overflow), int'(tbl[k].ov));
            check($sformatf("v%0d_udf", k), int'(underflow), int'(tbl[k].un));
            check($sformatf("v%0d_rv", k), int'(rd_valid), int'(tbl[k].rv));
            check($sformatf("v%0d_rdata", k), int'(rd_data), int'(tbl[k].rdd));
        end
        idle_inputs();

        // ---------------- wrap-around with scoreboard ----------------
        mc = 0;
        for (int c = 0; c < 60; c++) begin
            if (c < 60 - 12) begin
                wr_en = (c % 3 != 2) || (c >= 10 && c < 16);
                rd_en = (c % 4 != 0) && !(c >= 10 && c < 16);
            end else begin
                wr_en = 1'b0;
                rd_en = 1'b1;
            end
            wr_data = 4'(c * 7 + 3);
            ra = rd_en && (mc != 0);
            wa = wr_en && ((mc != 8) || ra);
            if (wa) sb.push_back(wr_data);
            if (wa && !ra) mc++;
            else if (ra && !wa) mc--;
            @(posedge clk); #1;
            check("wrap_count", int'(count), mc);
            check("wrap_rv", int'(rd_valid), int'(ra));
            if (rd_valid) begin
                if (sb.size() == 0) begin
                    check("wrap_sb_nonempty", 0, 1);
                end else begin
                    expw = sb.pop_front();
                    check("wrap_rdata", int'(rd_data), int'(expw));
                end
            end
        end
        idle_inputs();
        check("wrap_drained", sb.size(), 0);
        check("wrap_empty", int'(empty), 1);
        check("wrap_ovf", int'(overflow), 0);

        // ---------------- reset mid-operation ----------------
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; wr_data = 4'(i + 1);
            @(posedge clk); #1;
        end
        idle_inputs();
        check("mid_count5", int'(count), 5);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_count", int'(count), 0);
        check("mid_rst_empty", int'(empty), 1);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;
        check("mid_post_count", int'(count), 0);
        wr_en = 1'b1; wr_data = 4'hA;
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b1;
        @(posedge clk); #1;
        rd_en = 1'b0;
        check("mid_rv", int'(rd_valid), 1);
        check("mid_rdata", int'(rd_data), 32'hA);
        check("mid_empty", int'(empty), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
